// File: rtl/spi_slave.sv
// SPI mode-0 slave with synchronized SPI inputs, a one-deep tx buffer and an rx holding register.
// Define SPI_SLAVE_OVERRUN_DET_EN to enable the sticky rx_overrun flag (tied to 0 otherwise).
module spi_slave #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] IDLE_TX = DATA_W'(8'h00)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              dbg_state
);

  // Handshakes: tx_ready=1 means the tx buffer is empty; tx_load always writes
  // (overwriting a pending byte). rx_valid stays high until a cycle with rx_ack=1;
  // rx_ack while rx_valid=0 has no effect.

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic              sclk_s1_q, sclk_s1_d;
  logic              sclk_sync_q, sclk_sync_d;
  logic              sclk_dly_q, sclk_dly_d;
  logic              ss_s1_q, ss_s1_d;
  logic              ss_sync_q, ss_sync_d;
  logic              ss_dly_q, ss_dly_d;
  logic              mosi_s1_q, mosi_s1_d;
  logic              mosi_sync_q, mosi_sync_d;
  logic [1:0]        settle_q, settle_d;
  logic              ss_armed_q, ss_armed_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              wrap_q, wrap_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_pend_q, tx_pend_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              miso_q, miso_d;

  logic              sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic              frame_done, tx_take;
  logic [DATA_W-1:0] rx_frame;

  assign sclk_rise = sclk_sync_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q & sclk_dly_q;
  assign ss_fall   = ~ss_sync_q & ss_dly_q;
  assign ss_rise   = ss_sync_q & ~ss_dly_q;
  assign rx_frame  = {rx_shift_q[DATA_W-2:0], mosi_sync_q};

  always_comb begin
    sclk_s1_d    = sclk;
    sclk_sync_d  = sclk_s1_q;
    sclk_dly_d   = sclk_sync_q;
    ss_s1_d      = ss_n;
    ss_sync_d    = ss_s1_q;
    ss_dly_d     = ss_sync_q;
    mosi_s1_d    = mosi;
    mosi_sync_d  = mosi_s1_q;
    settle_d     = {settle_q[0], 1'b1};
    ss_armed_d   = ss_armed_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    wrap_d       = wrap_q;
    tx_buf_d     = tx_buf_q;
    tx_pend_d    = tx_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    frame_done   = 1'b0;
    tx_take      = 1'b0;

    // After reset the synchronizer holds ss_n=1 while the pin may be low; a frame
    // may only start once a real high level on ss_n has been observed.
    if (settle_q[1] && ss_sync_q) begin
      ss_armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && ss_armed_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          wrap_d    = 1'b0;
          tx_take   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          wrap_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_frame;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            wrap_d     = 1'b1;
            frame_done = 1'b1;
            tx_take    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          // The fall right after a wrap must keep the freshly reloaded MSB on miso.
          if (wrap_q) begin
            wrap_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_take) begin
      tx_shift_d = tx_pend_q ? tx_buf_q : IDLE_TX;
      tx_pend_d  = 1'b0;
    end
    if (tx_load) begin
      tx_buf_d  = tx_data;
      tx_pend_d = 1'b1;
    end

    if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
    if (frame_done) begin
      rx_data_d  = rx_frame;
      rx_valid_d = 1'b1;
    end

`ifdef SPI_SLAVE_OVERRUN_DET_EN
    if (frame_done && rx_valid_q && !rx_ack) begin
      rx_overrun_d = 1'b1;
    end
`else
    rx_overrun_d = 1'b0;
`endif

    miso_d = (state_d == ST_SHIFT) ? tx_shift_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q    <= 1'b0;
      sclk_sync_q  <= 1'b0;
      sclk_dly_q   <= 1'b0;
      ss_s1_q      <= 1'b1;
      ss_sync_q    <= 1'b1;
      ss_dly_q     <= 1'b1;
      mosi_s1_q    <= 1'b0;
      mosi_sync_q  <= 1'b0;
      settle_q     <= '0;
      ss_armed_q   <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      wrap_q       <= 1'b0;
      tx_buf_q     <= '0;
      tx_pend_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      sclk_s1_q    <= sclk_s1_d;
      sclk_sync_q  <= sclk_sync_d;
      sclk_dly_q   <= sclk_dly_d;
      ss_s1_q      <= ss_s1_d;
      ss_sync_q    <= ss_sync_d;
      ss_dly_q     <= ss_dly_d;
      mosi_s1_q    <= mosi_s1_d;
      mosi_sync_q  <= mosi_sync_d;
      settle_q     <= settle_d;
      ss_armed_q   <= ss_armed_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      wrap_q       <= wrap_d;
      tx_buf_q     <= tx_buf_d;
      tx_pend_q    <= tx_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      miso_q       <= miso_d;
    end
  end

  assign miso       = miso_q;
  assign tx_ready   = ~tx_pend_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 SPI master driver plus a byte-level
// model of the tx buffer and rx holding register.
module tb_spi_slave;

  localparam logic [7:0] IDLE_TX = 8'h00;

  logic       clk = 1'b0;
  logic       rst, sclk, ss_n, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_ready, rx_valid, rx_ack, rx_overrun, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic       m_pend;
  logic [7:0] m_buf, m_rx_data;
  logic       m_rx_valid, m_overrun;
  logic [7:0] exp_q[$];

  spi_slave #(.DATA_W(8), .IDLE_TX(IDLE_TX)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_pend = 1'b0; m_buf = '0; m_rx_data = '0; m_rx_valid = 1'b0; m_overrun = 1'b0;
    exp_q.delete();
  endfunction

  // A new frame takes the pending byte, otherwise the idle pattern.
  function automatic void model_take();
    exp_q.push_back(m_pend ? m_buf : IDLE_TX);
    m_pend = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ack_same);
`ifdef SPI_SLAVE_OVERRUN_DET_EN
    if (m_rx_valid && !ack_same) m_overrun = 1'b1;
`endif
    m_rx_valid = 1'b1;
    m_rx_data  = b;
    model_take();
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    tx_data = v; tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
    m_buf = v; m_pend = 1'b1;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
    m_rx_valid = 1'b0;
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    model_take();
    wait_clks(4);
  endtask

  task automatic ss_high();
    wait_clks(4);
    ss_n = 1'b1;
    exp_q.delete();
    wait_clks(6);
  endtask

  // Mode-0 master: mosi set in the low phase, miso sampled just before the rise.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit ack_last,
                          output logic [7:0] mi);
    int half;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      half = $urandom_range(3, 5);
      mosi = mo[7-i];
      wait_clks(half);
      mi = {mi[6:0], miso};
      sclk = 1'b1;
      if (ack_last && i == nbits - 1) begin
        // Two sync stages plus edge detect: the frame lands on the third edge.
        wait_clks(2);
        rx_ack = 1'b1;
        wait_clks(1);
        rx_ack = 1'b0;
        m_rx_valid = 1'b0;
        wait_clks(half - 3);
      end else begin
        wait_clks(half);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0;
    model_reset();
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
  endtask

  task automatic test_tx_rx();
    logic [7:0] mi, e;
    do_load(8'hA5);
    n_checks++; if (tx_ready !== !m_pend) begin n_fail++; $display("FAIL load_tx_ready: got %b expected %b", tx_ready, !m_pend); end
    ss_low();
    spi_byte(8'h3C, 8, 1'b0, mi);
    e = exp_q.pop_front();
    model_frame(8'h3C, 1'b0);
    ss_high();
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL txrx_miso: got %h expected %h", mi, e); end
    n_checks++; if (rx_data !== m_rx_data) begin n_fail++; $display("FAIL txrx_rx_data: got %h expected %h", rx_data, m_rx_data); end
    n_checks++; if (rx_valid !== m_rx_valid) begin n_fail++; $display("FAIL txrx_rx_valid: got %b expected %b", rx_valid, m_rx_valid); end
    n_checks++; if (tx_ready !== !m_pend) begin n_fail++; $display("FAIL txrx_tx_ready: got %b expected %b", tx_ready, !m_pend); end
  endtask

  task automatic test_idle_tx();
    logic [7:0] mi, e;
    do_ack();
    ss_low();
    spi_byte(8'h99, 8, 1'b0, mi);
    e = exp_q.pop_front();
    model_frame(8'h99, 1'b0);
    ss_high();
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL idle_miso: got %h expected %h", mi, e); end
    n_checks++; if (rx_data !== m_rx_data) begin n_fail++; $display("FAIL idle_rx_data: got %h expected %h", rx_data, m_rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi, e;
    do_ack();
    do_load(8'h6E);
    ss_low();
    spi_byte(8'h99, 8, 1'b0, mi);
    e = exp_q.pop_front();
    model_frame(8'h99, 1'b0);
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL b2b_miso0: got %h expected %h", mi, e); end
    spi_byte(8'hBB, 8, 1'b0, mi);
    e = exp_q.pop_front();
    model_frame(8'hBB, 1'b0);
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL b2b_miso1: got %h expected %h", mi, e); end
    ss_high();
    n_checks++; if (rx_data !== m_rx_data) begin n_fail++; $display("FAIL b2b_rx_data: got %h expected %h", rx_data, m_rx_data); end
    n_checks++; if (rx_valid !== m_rx_valid) begin n_fail++; $display("FAIL b2b_rx_valid: got %b expected %b", rx_valid, m_rx_valid); end
    n_checks++; if (rx_overrun !== m_overrun) begin n_fail++; $display("FAIL b2b_overrun: got %b expected %b", rx_overrun, m_overrun); end
  endtask

  task automatic test_partial();
    logic [7:0] mi, e;
    do_ack();
    ss_low();
    spi_byte(8'hFF, 5, 1'b0, mi);
    ss_high();
    n_checks++; if (rx_valid !== m_rx_valid) begin n_fail++; $display("FAIL partial_rx_valid: got %b expected %b", rx_valid, m_rx_valid); end
    ss_low();
    spi_byte(8'h12, 8, 1'b0, mi);
    e = exp_q.pop_front();
    model_frame(8'h12, 1'b0);
    ss_high();
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL partial_miso: got %h expected %h", mi, e); end
    n_checks++; if (rx_data !== m_rx_data) begin n_fail++; $display("FAIL partial_rx_data: got %h expected %h", rx_data, m_rx_data); end
    n_checks++; if (rx_valid !== m_rx_valid) begin n_fail++; $display("FAIL partial_valid2: got %b expected %b", rx_valid, m_rx_valid); end
  endtask

  task automatic test_ack_same();
    logic [7:0] mi, e;
    do_load(8'hC6);
    ss_low();
    spi_byte(8'h4D, 8, 1'b1, mi);
    e = exp_q.pop_front();
    model_frame(8'h4D, 1'b1);
    ss_high();
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL acksame_miso: got %h expected %h", mi, e); end
    n_checks++; if (rx_valid !== m_rx_valid) begin n_fail++; $display("FAIL acksame_valid: got %b expected %b", rx_valid, m_rx_valid); end
    n_checks++; if (rx_data !== m_rx_data) begin n_fail++; $display("FAIL acksame_data: got %h expected %h", rx_data, m_rx_data); end
    n_checks++; if (rx_overrun !== m_overrun) begin n_fail++; $display("FAIL acksame_overrun: got %b expected %b", rx_overrun, m_overrun); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, e;
    do_load(8'h77);
    ss_low();
    spi_byte(8'hF0, 4, 1'b0, mi);
    rst = 1'b1;
    wait_clks(1);
    model_reset();
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b expected 0", miso); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready: got %b expected 1", tx_ready); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b expected 0", rx_overrun); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got %b expected 0", dbg_state); end
    rst = 1'b0;
    wait_clks(2);
    // ss_n is still low: without a fresh fall these bits must be ignored.
    spi_byte(8'hC3, 8, 1'b0, mi);
    n_checks++; if (mi !== 8'h00) begin n_fail++; $display("FAIL rstmid_stale_miso: got %h expected 00", mi); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_valid: got %b expected 0", rx_valid); end
    ss_high();
    ss_low();
    spi_byte(8'h5A, 8, 1'b0, mi);
    e = exp_q.pop_front();
    model_frame(8'h5A, 1'b0);
    ss_high();
    n_checks++; if (mi !== e) begin n_fail++; $display("FAIL rstmid_miso2: got %h expected %h", mi, e); end
    n_checks++; if (rx_data !== m_rx_data) begin n_fail++; $display("FAIL rstmid_rx_data2: got %h expected %h", rx_data, m_rx_data); end
    n_checks++; if (rx_valid !== m_rx_valid) begin n_fail++; $display("FAIL rstmid_valid2: got %b expected %b", rx_valid, m_rx_valid); end
  endtask

  task automatic test_random();
    logic [7:0] mi, e, b;
    int nfr;
    bit ack_l;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
      if ($urandom_range(0, 2) == 0) do_load(8'($urandom));
      if ($urandom_range(0, 1) == 1) do_ack();
      nfr = $urandom_range(1, 3);
      ss_low();
      for (int f = 0; f < nfr; f++) begin
        b = 8'($urandom);
        ack_l = ($urandom_range(0, 3) == 0);
        spi_byte(b, 8, ack_l, mi);
        e = exp_q.pop_front();
        model_frame(b, ack_l);
        n_checks++; if (mi !== e) begin n_fail++; $display("FAIL rand_miso it=%0d f=%0d: got %h expected %h", it, f, mi, e); end
      end
      if ($urandom_range(0, 3) == 0) spi_byte(8'($urandom), $urandom_range(1, 7), 1'b0, mi);
      ss_high();
      n_checks++; if (rx_data !== m_rx_data) begin n_fail++; $display("FAIL rand_rx_data it=%0d: got %h expected %h", it, rx_data, m_rx_data); end
      n_checks++; if (rx_valid !== m_rx_valid) begin n_fail++; $display("FAIL rand_rx_valid it=%0d: got %b expected %b", it, rx_valid, m_rx_valid); end
      n_checks++; if (tx_ready !== !m_pend) begin n_fail++; $display("FAIL rand_tx_ready it=%0d: got %b expected %b", it, tx_ready, !m_pend); end
      n_checks++; if (rx_overrun !== m_overrun) begin n_fail++; $display("FAIL rand_overrun it=%0d: got %b expected %b", it, rx_overrun, m_overrun); end
    end
  endtask

  initial begin
    test_reset();
    test_tx_rx();
    test_idle_tx();
    test_back_to_back();
    test_partial();
    test_ack_same();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8: frame width in bits.
REQ-002 SHALL have parameter IDLE_TX, default 8'h00: byte shifted out when no tx byte is pending.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sclk, input, 1: SPI clock from the master, asynchronous to clk.
REQ-006 SHALL have port ss_n, input, 1: active-low slave select from the master, asynchronous.
REQ-007 SHALL have port mosi, input, 1: serial data from the master, asynchronous.
REQ-008 SHALL have port miso, output, 1: serial data to the master.
REQ-009 SHALL have port tx_data, input, DATA_W: next byte to return to the master.
REQ-010 SHALL have port tx_load, input, 1: writes tx_data into the tx buffer.
REQ-011 SHALL have port tx_ready, output, 1: high when the tx buffer is empty.
REQ-012 SHALL have port rx_data, output, DATA_W: last complete received frame.
REQ-013 SHALL have port rx_valid, output, 1: rx_data holds an unacknowledged frame.
REQ-014 SHALL have port rx_ack, input, 1: consumer acknowledges rx_data.
REQ-015 SHALL have port rx_overrun, output, 1: sticky flag, a frame was lost.

Function
REQ-016 SHALL pass sclk, ss_n and mosi each through a 2-FF synchronizer; sync reset values are sclk 0, ss_n 1, mosi 0.
REQ-017 SHALL detect sclk rise and fall, and ss_n fall and rise, by comparing the synchronized value with a 1-cycle delayed copy.
REQ-018 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first; mosi sampled on sclk rise, miso updated on sclk fall.
REQ-019 SHALL operate correctly when each sclk high and low phase lasts at least 3 clk cycles.
REQ-020 SHALL have states IDLE and SHIFT: IDLE->SHIFT on ss_n fall; SHIFT->IDLE on ss_n rise; no other transitions.
REQ-021 SHALL, on entry to SHIFT, reset bit_cnt to 0 and load tx_shift from the tx buffer if pending, else from IDLE_TX.
REQ-022 SHALL drive miso = tx_shift MSB in SHIFT and 0 in IDLE.
REQ-023 SHALL, on each sclk rise in SHIFT, shift mosi_sync into rx_shift LSB and increment bit_cnt.
REQ-024 SHALL, on the sclk rise of bit DATA_W-1, do all of the following: write the completed frame to rx_data, set rx_valid on the next cycle, wrap bit_cnt to 0, and reload tx_shift per REQ-021.
REQ-025 SHALL, on each sclk fall in SHIFT other than the fall after a wrap, shift tx_shift left by one.
REQ-026 SHALL, on ss_n rise mid-frame (bit_cnt != 0), discard the partial frame, leave rx_valid and rx_data unchanged, and go to IDLE.
REQ-027 SHALL keep rx_valid high until a cycle with rx_ack=1; rx_ack with rx_valid=0 is ignored.
REQ-028 SHALL, when a frame completes in the same cycle as rx_ack, set rx_valid=1 with the new data.
REQ-029 SHALL, when a frame completes with rx_valid=1 and no rx_ack, overwrite rx_data and keep rx_valid=1.
REQ-030 SHALL, on tx_load, write tx_data into the buffer and set pending; tx_ready = ~pending.
REQ-031 SHALL, when tx_load and a buffer transfer occur in the same cycle, transfer the old buffer value, store the new value, and keep pending=1.
REQ-032 SHALL, on tx_load while pending, overwrite the buffer; the previous value is lost.

Reset
REQ-033 SHALL, while rst=1, force: state IDLE, miso 0, tx_ready 1, rx_valid 0, rx_data 0, rx_overrun 0, bit_cnt 0, shift registers 0.
REQ-034 SHALL give rst priority over all inputs, including mid-frame; after reset the next frame begins only on a fresh ss_n fall.

Configuration
REQ-035 SHALL gate rx_overrun logic with macro SPI_SLAVE_OVERRUN_DET_EN.
REQ-036 SHALL, with SPI_SLAVE_OVERRUN_DET_EN defined, set rx_overrun on the REQ-029 condition and clear it only by reset.
REQ-037 SHALL, without SPI_SLAVE_OVERRUN_DET_EN, keep the rx_overrun port and tie it to 0.

Verification
REQ-038 SHALL cover: tx_load 8'hA5, master sends 8'h3C -> miso bits 1010_0101, rx_data=8'h3C, rx_valid=1, tx_ready=1.
REQ-039 SHALL cover: no tx_load, master sends 8'h99 -> miso carries 8'h00, rx_data=8'h99.
REQ-040 SHALL cover: two back-to-back frames 8'h99, 8'hBB under one ss_n low with no ack -> rx_data=8'hBB, rx_valid=1, rx_overrun=1 (macro on) or 0 (macro off).
REQ-041 SHALL cover: ss_n raised after 5 bits of 8'hFF -> rx_valid stays 0; next full frame 8'h12 -> rx_data=8'h12.
REQ-042 SHALL cover: rst pulsed mid-frame -> all outputs at reset values next cycle; a subsequent frame 8'h5A is received correctly.
REQ-043 SHALL cover: rx_ack on the same cycle a frame completes -> rx_valid remains 1 with the new data.
